// File: rtl/tm_input_ctrl.sv
// Front end for the Turing machine core: turns raw buttons and switches into clean
// Next/Done strobes plus the input_data nibble, for both program entry and execution.
module tm_input_ctrl #(
    parameter int DATA_W      = 4,
    parameter int MAX_ENTRIES = 64,
    parameter int DB_CYCLES   = 4,
    parameter int STEP_CYCLES = 16
) (
    input  logic              clock,
    input  logic              Reset,
    input  logic              btn_next_raw,
    input  logic              btn_done_raw,
    input  logic [DATA_W-1:0] sw_data,
    input  logic              run_en,
    output logic              Next,
    output logic              Done,
    output logic [DATA_W-1:0] input_data,
    output logic [1:0]        mode,
    output logic [6:0]        entry_cnt
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam int TMR_W = $clog2(STEP_CYCLES);

    typedef enum logic [1:0] {
        MODE_LOAD       = 2'd0,
        MODE_RUN_MANUAL = 2'd1,
        MODE_RUN_AUTO   = 2'd2
    } mode_t;

    logic [1:0]        btnRaw;
    logic [1:0]        btnMeta_q;
    logic [1:0]        btnSync_q;
    logic [1:0]        pressEvt;
    logic [DATA_W-1:0] swMeta_q;
    logic [DATA_W-1:0] swSync_q;
    logic              runMeta_q;
    logic              runSync_q;

    mode_t             mode_q;
    logic              next_q;
    logic              done_q;
    logic [DATA_W-1:0] inputData_q;
    logic [6:0]        entryCnt_q;
    logic [TMR_W-1:0]  timer_q;

    logic nextEvt;
    logic doneEvt;
    logic autoWrap;

    assign btnRaw = {btn_done_raw, btn_next_raw};

    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            btnMeta_q <= '0;
            btnSync_q <= '0;
            swMeta_q  <= '0;
            swSync_q  <= '0;
            runMeta_q <= 1'b0;
            runSync_q <= 1'b0;
        end else begin
            btnMeta_q <= btnRaw;
            btnSync_q <= btnMeta_q;
            swMeta_q  <= sw_data;
            swSync_q  <= swMeta_q;
            runMeta_q <= run_en;
            runSync_q <= runMeta_q;
        end
    end

    // Bit 0 is Next, bit 1 is Done; the press event is registered so the
    // core-side strobe is a clean flop output one edge later.
    for (genvar b = 0; b < 2; b++) begin : g_db
        logic             level_q;
        logic             prev_q;
        logic             evt_q;
        logic [CNT_W-1:0] stableCnt_q;

        always_ff @(posedge clock or posedge Reset) begin
            if (Reset) begin
                level_q     <= 1'b0;
                prev_q      <= 1'b0;
                evt_q       <= 1'b0;
                stableCnt_q <= '0;
            end else begin
                prev_q <= level_q;
                evt_q  <= level_q & ~prev_q;
                if (btnSync_q[b] == level_q) begin
                    stableCnt_q <= '0;
                end else if (stableCnt_q == CNT_W'(DB_CYCLES - 1)) begin
                    level_q     <= btnSync_q[b];
                    stableCnt_q <= '0;
                end else begin
                    stableCnt_q <= stableCnt_q + CNT_W'(1);
                end
            end
        end

        assign pressEvt[b] = evt_q;
    end

    assign nextEvt  = pressEvt[0];
    assign doneEvt  = pressEvt[1];
    assign autoWrap = (mode_q == MODE_RUN_AUTO) && runSync_q &&
                      (timer_q == TMR_W'(STEP_CYCLES - 1));

    // Suppressing a strobe right after another keeps Next from ever being
    // high on two consecutive cycles, even when an auto wrap meets a press.
    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            mode_q      <= MODE_LOAD;
            next_q      <= 1'b0;
            done_q      <= 1'b0;
            inputData_q <= '0;
            entryCnt_q  <= '0;
            timer_q     <= '0;
        end else begin
            next_q <= 1'b0;
            done_q <= 1'b0;
            case (mode_q)
                MODE_LOAD: begin
                    timer_q <= '0;
                    if (doneEvt && (entryCnt_q != 7'd0)) begin
                        done_q <= 1'b1;
                        mode_q <= runSync_q ? MODE_RUN_AUTO : MODE_RUN_MANUAL;
                    end else if (nextEvt && (entryCnt_q < 7'(MAX_ENTRIES))) begin
                        next_q      <= 1'b1;
                        inputData_q <= swSync_q;
                        entryCnt_q  <= entryCnt_q + 7'd1;
                    end
                end
                default: begin
                    mode_q <= runSync_q ? MODE_RUN_AUTO : MODE_RUN_MANUAL;
                    next_q <= (nextEvt || autoWrap) && !next_q;
                    if (!runSync_q || (mode_q != MODE_RUN_AUTO) || nextEvt || autoWrap) begin
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
            endcase
        end
    end

    assign Next       = next_q;
    assign Done       = done_q;
    assign input_data = inputData_q;
    assign mode       = mode_q;
    assign entry_cnt  = entryCnt_q;

endmodule

// File: tb/tb_tm_input_ctrl.sv
// Directed bench for tm_input_ctrl: hand-timed button presses with expected strobe
// cycles, latched nibbles, counts and mode values worked out from the default parameters.
module tb_tm_input_ctrl;

    logic       clock;
    logic       Reset;
    logic       btn_next_raw;
    logic       btn_done_raw;
    logic [3:0] sw_data;
    logic       run_en;
    logic       Next;
    logic       Done;
    logic [3:0] input_data;
    logic [1:0] mode;
    logic [6:0] entry_cnt;

    int assertCount = 0;
    int failCount   = 0;
    int cyc         = 0;
    int consecNext  = 0;
    logic prevNext  = 1'b0;
    int nextQ[$];
    int doneQ[$];
    int rc;
    int sc;
    int expAuto[10];

    tm_input_ctrl dut (
        .clock       (clock),
        .Reset       (Reset),
        .btn_next_raw(btn_next_raw),
        .btn_done_raw(btn_done_raw),
        .sw_data     (sw_data),
        .run_en      (run_en),
        .Next        (Next),
        .Done        (Done),
        .input_data  (input_data),
        .mode        (mode),
        .entry_cnt   (entry_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Strobes are logged by the index of the edge that raised them.
    always @(posedge clock) begin
        #1;
        cyc = cyc + 1;
        if (Next) begin
            nextQ.push_back(cyc);
            if (prevNext) consecNext = consecNext + 1;
        end
        prevNext = Next;
        if (Done) doneQ.push_back(cyc);
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount = assertCount + 1;
        if (observed !== expected) begin
            failCount = failCount + 1;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Press and hold for 10 clocks, then release for 10; atCyc > 0 aligns the press.
    task automatic applyStimulus(input logic pressNext, input logic pressDone,
                                 input int atCyc, output int setCyc);
        int guard;
        guard = 0;
        @(negedge clock);
        while (cyc < atCyc && guard < 2000) begin
            @(negedge clock);
            guard = guard + 1;
        end
        if (atCyc > 0) checkOutput("press_align", cyc, atCyc);
        btn_next_raw = pressNext;
        btn_done_raw = pressDone;
        setCyc = cyc;
        repeat (10) @(negedge clock);
        btn_next_raw = 1'b0;
        btn_done_raw = 1'b0;
        repeat (10) @(negedge clock);
    endtask

    initial begin
        Reset = 1'b1;
        btn_next_raw = 1'b0;
        btn_done_raw = 1'b0;
        sw_data = 4'd0;
        run_en = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("rst_next", Next, 0);
        checkOutput("rst_done", Done, 0);
        checkOutput("rst_data", input_data, 0);
        checkOutput("rst_mode", mode, 0);
        checkOutput("rst_cnt", entry_cnt, 0);
        Reset = 1'b0;

        // Done with nothing loaded
        applyStimulus(1'b0, 1'b1, 0, sc);
        checkOutput("done_empty_strobes", doneQ.size(), 0);
        checkOutput("done_empty_mode", mode, 0);

        // Three clean entries
        sw_data = 4'd3;
        nextQ.delete();
        applyStimulus(1'b1, 1'b0, 0, sc);
        checkOutput("load1_latency", (nextQ.size() > 0) ? nextQ[0] : -1, sc + 8);
        checkOutput("load1_data", input_data, 3);
        sw_data = 4'd1;
        applyStimulus(1'b1, 1'b0, 0, sc);
        checkOutput("load2_data", input_data, 1);
        sw_data = 4'd2;
        applyStimulus(1'b1, 1'b0, 0, sc);
        checkOutput("load3_data", input_data, 2);
        checkOutput("load3_cnt", entry_cnt, 3);
        checkOutput("load3_strobes", nextQ.size(), 3);

        // Bouncy press
        sw_data = 4'd7;
        nextQ.delete();
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            btn_next_raw = 1'b1;
            repeat (1) @(negedge clock);
            @(negedge clock);
            btn_next_raw = 1'b0;
            repeat (1) @(negedge clock);
        end
        @(negedge clock);
        btn_next_raw = 1'b1;
        sc = cyc;
        repeat (10) @(negedge clock);
        btn_next_raw = 1'b0;
        repeat (10) @(negedge clock);
        checkOutput("bounce_strobes", nextQ.size(), 1);
        checkOutput("bounce_latency", (nextQ.size() > 0) ? nextQ[0] : -1, sc + 8);
        checkOutput("bounce_cnt", entry_cnt, 4);
        checkOutput("bounce_data", input_data, 7);

        // Asynchronous reset in the middle of a debounce
        sw_data = 4'd9;
        nextQ.delete();
        @(negedge clock);
        btn_next_raw = 1'b1;
        repeat (3) @(negedge clock);
        #2 Reset = 1'b1;
        #1;
        checkOutput("async_rst_data", input_data, 0);
        checkOutput("async_rst_cnt", entry_cnt, 0);
        checkOutput("async_rst_mode", mode, 0);
        checkOutput("async_rst_next", Next, 0);
        repeat (2) @(negedge clock);
        Reset = 1'b0;
        sc = cyc;
        nextQ.delete();
        repeat (10) @(negedge clock);
        btn_next_raw = 1'b0;
        repeat (10) @(negedge clock);
        checkOutput("post_rst_strobes", nextQ.size(), 1);
        checkOutput("post_rst_latency", (nextQ.size() > 0) ? nextQ[0] : -1, sc + 8);
        checkOutput("post_rst_cnt", entry_cnt, 1);
        checkOutput("post_rst_data", input_data, 9);

        // Fill to capacity, then one press too many
        nextQ.delete();
        for (int i = 2; i <= 64; i++) begin
            sw_data = 4'(i);
            applyStimulus(1'b1, 1'b0, 0, sc);
        end
        checkOutput("full_strobes", nextQ.size(), 63);
        checkOutput("full_cnt", entry_cnt, 64);
        checkOutput("full_data", input_data, 0);
        sw_data = 4'd5;
        nextQ.delete();
        applyStimulus(1'b1, 1'b0, 0, sc);
        checkOutput("overflow_strobes", nextQ.size(), 0);
        checkOutput("overflow_cnt", entry_cnt, 64);
        checkOutput("overflow_data", input_data, 0);

        // Fresh program of five entries, then Next and Done together
        @(negedge clock);
        Reset = 1'b1;
        repeat (2) @(negedge clock);
        Reset = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            sw_data = 4'(i);
            applyStimulus(1'b1, 1'b0, 0, sc);
        end
        checkOutput("five_cnt", entry_cnt, 5);
        run_en = 1'b0;
        nextQ.delete();
        doneQ.delete();
        applyStimulus(1'b1, 1'b1, 0, sc);
        checkOutput("both_done_strobes", doneQ.size(), 1);
        checkOutput("both_done_latency", (doneQ.size() > 0) ? doneQ[0] : -1, sc + 8);
        checkOutput("both_next_strobes", nextQ.size(), 0);
        checkOutput("both_cnt", entry_cnt, 5);
        checkOutput("manual_mode", mode, 1);

        // Manual stepping
        nextQ.delete();
        applyStimulus(1'b1, 1'b0, 0, sc);
        checkOutput("manual_strobes", nextQ.size(), 1);
        checkOutput("manual_latency", (nextQ.size() > 0) ? nextQ[0] : -1, sc + 8);
        checkOutput("manual_data", input_data, 5);
        checkOutput("manual_cnt", entry_cnt, 5);

        // Auto stepping: wrap-aligned press at +99, off-wrap press at +128
        @(negedge clock);
        run_en = 1'b1;
        rc = cyc;
        nextQ.delete();
        repeat (3) @(negedge clock);
        checkOutput("auto_mode", mode, 2);
        applyStimulus(1'b1, 1'b0, rc + 91, sc);
        applyStimulus(1'b1, 1'b0, rc + 120, sc);
        repeat (25) @(negedge clock);
        expAuto = '{19, 35, 51, 67, 83, 99, 115, 128, 144, 160};
        checkOutput("auto_strobes", nextQ.size(), 10);
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("auto_strobe%0d", i),
                        (i < nextQ.size()) ? nextQ[i] - rc : -1, expAuto[i]);
        end

        // Done and switch changes are ignored while running
        doneQ.delete();
        sw_data = 4'd15;
        applyStimulus(1'b0, 1'b1, 0, sc);
        checkOutput("run_done_strobes", doneQ.size(), 0);
        checkOutput("run_data_hold", input_data, 5);
        checkOutput("run_cnt_hold", entry_cnt, 5);
        checkOutput("run_mode_auto", mode, 2);
        @(negedge clock);
        run_en = 1'b0;
        repeat (4) @(negedge clock);
        checkOutput("run_mode_back_manual", mode, 1);
        checkOutput("next_consecutive", consecNext, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
